demod_mode_ctrl: RTL and testbench

- Sequences demodulator mode changes for the baseband demod chain so that audio never clicks or glitches.
- Sits between the control register interface and the demodulator. It drives the demod `type` select and a synchronous flush (pipeline clear). It applies a gain ramp to the demod L/R output stream.
- On a mode request it ramps the audio down, switches and flushes the demod, waits a settle interval, then ramps the audio back up.

---
 rtl/demod_mode_ctrl_if.sv | 27 ++
 rtl/demod_mode_ctrl.sv | 199 +++++++++++++++++++
 tb/tb_demod_mode_ctrl.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/demod_mode_ctrl_if.sv
// Control/sample bundle between the register block, demod_mode_ctrl and the demodulator.
// master: request and sample source; slave: demod_mode_ctrl.
interface demod_mode_ctrl_if #(
    parameter int dsz = 16
);
    logic [2:0]            req_type;
    logic                  req_stb;
    logic signed [dsz-1:0] l_in;
    logic signed [dsz-1:0] r_in;
    logic                  in_valid;
    logic [2:0]            demod_type;   // "type" is a reserved word
    logic                  flush;
    logic signed [dsz-1:0] l_out;
    logic signed [dsz-1:0] r_out;
    logic                  valid;
    logic                  busy;

    modport master (
        output req_type, req_stb, l_in, r_in, in_valid,
        input  demod_type, flush, l_out, r_out, valid, busy
    );

    modport slave (
        input  req_type, req_stb, l_in, r_in, in_valid,
        output demod_type, flush, l_out, r_out, valid, busy
    );
endinterface

// File: rtl/demod_mode_ctrl.sv
// Click-free demod mode sequencer: ramp down, switch+flush, settle, ramp up.
// Optional stall timeout (and its tmo parameter) enabled by DEMOD_MODE_CTRL_TIMEOUT_EN.
module demod_mode_ctrl #(
    parameter int dsz       = 16,
    parameter int gsz       = 8,
    parameter int settle    = 1024,
    parameter int flush_len = 4
`ifdef DEMOD_MODE_CTRL_TIMEOUT_EN
    ,
    parameter int tmo       = 4096
`endif
) (
    input  logic             clk,
    input  logic             reset,
    demod_mode_ctrl_if.slave bus
);
    localparam int GW = gsz + 1;
    localparam int PW = dsz + gsz + 2;
    localparam int SW = $clog2(settle + 1);
    localparam int FW = $clog2(flush_len + 1);
    localparam logic [GW-1:0] UNITY       = {1'b1, {gsz{1'b0}}};
    localparam logic [SW-1:0] SETTLE_LAST = SW'(settle - 1);
    localparam logic [FW-1:0] FLUSH_LAST  = FW'(flush_len - 1);

    typedef enum logic [2:0] {RUN, RAMP_DN, SWITCH, SETTLE, RAMP_UP} state_t;

    state_t          state_reg, state_next;
    logic            pending_reg, pending_next;
    logic [2:0]      pend_type_reg, pend_eff;
    logic [2:0]      type_reg;
    logic            flush_reg, busy_reg, valid_reg;
    logic [GW-1:0]   gain_reg;
    logic [SW-1:0]   settle_cnt_reg;
    logic [FW-1:0]   flush_cnt_reg;
    logic            req_diff, step;

    // ---------------- stall timeout ----------------
`ifdef DEMOD_MODE_CTRL_TIMEOUT_EN
    localparam int TW = $clog2(tmo + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(tmo - 1);

    logic [TW-1:0] tmo_cnt_reg;
    logic          tmo_hit;

    assign tmo_hit = !bus.in_valid && (tmo_cnt_reg == TMO_LAST);
    assign step    = bus.in_valid || tmo_hit;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            tmo_cnt_reg <= '0;
        else if (bus.in_valid || tmo_hit)
            tmo_cnt_reg <= '0;
        else
            tmo_cnt_reg <= tmo_cnt_reg + 1'b1;
    end
`else
    assign step = bus.in_valid;
`endif

    // ---------------- gain datapath, one per channel ----------------
    logic signed [dsz-1:0] smp_in  [2];
    logic signed [dsz-1:0] smp_out [2];
    logic signed [gsz+1:0] gain_s;

    assign smp_in[0] = bus.l_in;
    assign smp_in[1] = bus.r_in;
    assign gain_s    = $signed({1'b0, gain_reg});

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_chan
            logic signed [PW-1:0]  prod;
            logic signed [dsz-1:0] out_reg;

            // Full-width product keeps unity gain exact for the most negative sample.
            assign prod = PW'(smp_in[gi]) * PW'(gain_s);

            always_ff @(posedge clk or negedge reset) begin
                if (!reset)
                    out_reg <= '0;
                else if (bus.in_valid)
                    out_reg <= dsz'(prod >>> gsz);
            end

            assign smp_out[gi] = out_reg;
        end
    endgenerate

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            valid_reg <= 1'b0;
        else
            valid_reg <= bus.in_valid;
    end

    // ---------------- request handling ----------------
    // state_next/pending_next reflect only the request; the step below may advance further.
    assign req_diff = bus.req_stb && (bus.req_type != type_reg);
    assign pend_eff = bus.req_stb ? bus.req_type : pend_type_reg;

    always_comb begin
        state_next   = state_reg;
        pending_next = pending_reg;
        if (bus.req_stb) begin
            case (state_reg)
                RUN:     if (req_diff) state_next = RAMP_DN;
                RAMP_DN: state_next = RAMP_DN;
                default: begin
                    if (req_diff) begin
                        state_next   = RAMP_DN;
                        pending_next = 1'b1;
                    end else begin
                        pending_next = 1'b0;
                    end
                end
            endcase
        end
    end

    // ---------------- sequencer ----------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg      <= SETTLE;
            pending_reg    <= 1'b0;
            pend_type_reg  <= '0;
            type_reg       <= '0;
            flush_reg      <= 1'b0;
            busy_reg       <= 1'b1;
            gain_reg       <= '0;
            settle_cnt_reg <= '0;
            flush_cnt_reg  <= '0;
        end else begin
            state_reg   <= state_next;
            pending_reg <= pending_next;
            busy_reg    <= (state_next != RUN);
            flush_reg   <= 1'b0;
            if (bus.req_stb && (state_reg != RUN || req_diff))
                pend_type_reg <= bus.req_type;

            case (state_next)
                RUN: gain_reg <= UNITY;
                RAMP_DN: begin
                    if (step) begin
                        // Also covers entry at gain 0 (abort from SWITCH/SETTLE).
                        if (gain_reg <= GW'(1)) begin
                            gain_reg      <= '0;
                            state_reg     <= SWITCH;
                            type_reg      <= pend_eff;
                            flush_reg     <= 1'b1;
                            flush_cnt_reg <= '0;
                            pending_reg   <= 1'b0;
                        end else begin
                            gain_reg <= gain_reg - 1'b1;
                        end
                    end
                end
                SWITCH: begin
                    if (flush_cnt_reg == FLUSH_LAST) begin
                        state_reg      <= SETTLE;
                        settle_cnt_reg <= '0;
                    end else begin
                        flush_reg     <= 1'b1;
                        flush_cnt_reg <= flush_cnt_reg + 1'b1;
                    end
                end
                SETTLE: begin
                    gain_reg <= '0;
                    if (step) begin
                        if (settle_cnt_reg == SETTLE_LAST) begin
                            state_reg <= RAMP_UP;
                            gain_reg  <= GW'(1);
                        end else begin
                            settle_cnt_reg <= settle_cnt_reg + 1'b1;
                        end
                    end
                end
                RAMP_UP: begin
                    if (step) begin
                        if (gain_reg == UNITY - 1'b1) begin
                            gain_reg  <= UNITY;
                            state_reg <= pending_next ? RAMP_DN : RUN;
                            busy_reg  <= pending_next;
                        end else begin
                            gain_reg <= gain_reg + 1'b1;
                        end
                    end
                end
                default: state_reg <= SETTLE;
            endcase
        end
    end

    assign bus.demod_type = type_reg;
    assign bus.flush      = flush_reg;
    assign bus.l_out      = smp_out[0];
    assign bus.r_out      = smp_out[1];
    assign bus.valid      = valid_reg;
    assign bus.busy       = busy_reg;
endmodule

// File: tb/tb_demod_mode_ctrl.sv
// Directed bench for demod_mode_ctrl: gsz=8, settle=16, flush_len=4, in_valid every 4 clocks.
module tb_demod_mode_ctrl;
    logic clk = 1'b0;
    logic reset = 1'b0;

    demod_mode_ctrl_if #(.dsz(16)) bus();

    demod_mode_ctrl #(
        .dsz(16), .gsz(8), .settle(16), .flush_len(4)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        int l;
        int r;
        int el;
        int er;
    } vec_t;

    vec_t vecs [5];
    int   checks = 0;
    int   errors = 0;
    int   got_l, got_r;
    int   flush_clks = 0;
    int   switches = 0;
    logic flush_d = 1'b0;
    int   fc0, sw0;

    // Flush activity monitor: high clocks and number of distinct flush pulses.
    always @(negedge clk) begin
        if (reset) begin
            if (bus.flush) flush_clks <= flush_clks + 1;
            if (bus.flush && !flush_d) switches <= switches + 1;
        end
        flush_d <= bus.flush;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete, checks=%0d", checks);
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic strobe(input int t);
        bus.req_type = 3'(t);
        bus.req_stb  = 1'b1;
        tick();
        bus.req_stb  = 1'b0;
    endtask

    task automatic send(input int lv, input int rv);
        bus.l_in     = lv[15:0];
        bus.r_in     = rv[15:0];
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        got_l = int'(bus.l_out);
        got_r = int'(bus.r_out);
        check("valid_hi", int'(bus.valid), 1);
        tick();
        check("valid_lo", int'(bus.valid), 0);
        tick();
        tick();
    endtask

    // Sample i of the phase is expected to use gain g0 + dg*i.
    task automatic drive_phase(input string nm, input int n, input int g0, input int dg,
                               input int lv, input int rv);
        int g, el, er, e0;
        e0 = errors;
        for (int i = 0; i < n; i++) begin
            g  = g0 + dg * i;
            el = (lv * g) >>> 8;
            er = (rv * g) >>> 8;
            send(lv, rv);
            check($sformatf("%s_l[%0d]", nm, i), got_l, el);
            check($sformatf("%s_r[%0d]", nm, i), got_r, er);
        end
        $display("phase %s: %0d samples gain %0d..%0d, errors in phase %0d",
                 nm, n, g0, g0 + dg * (n - 1), errors - e0);
    endtask

    initial begin
        vecs[0] = '{-32768,  32767, -32768,  32767};
        vecs[1] = '{  1000,  -1000,   1000,  -1000};
        vecs[2] = '{     0,     -1,      0,     -1};
        vecs[3] = '{ 12345, -23456,  12345, -23456};
        vecs[4] = '{ 32767, -32768,  32767, -32768};

        bus.req_type = '0;
        bus.req_stb  = 1'b0;
        bus.l_in     = '0;
        bus.r_in     = '0;
        bus.in_valid = 1'b0;

        // Reset state
        repeat (3) tick();
        check("rst_type",  int'(bus.demod_type), 0);
        check("rst_flush", int'(bus.flush), 0);
        check("rst_l",     int'(bus.l_out), 0);
        check("rst_r",     int'(bus.r_out), 0);
        check("rst_valid", int'(bus.valid), 0);
        check("rst_busy",  int'(bus.busy), 1);
        reset = 1'b1;
        tick();

        // Start-up: 16 settle samples, then ramp 1..256
        drive_phase("start_settle", 16, 0, 0, 1000, -1000);
        check("start_busy_settle", int'(bus.busy), 1);
        drive_phase("start_ramp", 254, 1, 1, 1000, -1000);
        check("start_busy_ramp", int'(bus.busy), 1);
        send(1000, -1000);
        check("start_g255_l", got_l, 996);
        check("start_busy_run", int'(bus.busy), 0);
        send(1000, -1000);
        check("start_full_l", got_l, 1000);
        check("start_full_r", got_r, -1000);
        check("start_switches", switches, 0);

        // Unity-gain passthrough table with hold between strobes
        for (int v = 0; v < 5; v++) begin
            send(vecs[v].l, vecs[v].r);
            check($sformatf("vec%0d_l", v), got_l, vecs[v].el);
            check($sformatf("vec%0d_r", v), got_r, vecs[v].er);
            bus.l_in = 16'sd5;
            bus.r_in = 16'sd7;
            tick();
            check($sformatf("vec%0d_hold_l", v), int'(bus.l_out), vecs[v].el);
            check($sformatf("vec%0d_hold_r", v), int'(bus.r_out), vecs[v].er);
            $display("vector %0d: l_in=%0d r_in=%0d -> l_out=%0d r_out=%0d",
                     v, vecs[v].l, vecs[v].r, got_l, got_r);
        end

        // Same-type request in RUN (type 0) is ignored
        fc0 = flush_clks;
        strobe(0);
        tick();
        check("same0_busy", int'(bus.busy), 0);
        check("same0_flush", flush_clks - fc0, 0);

        // Mode change to NBFM
        fc0 = flush_clks;
        sw0 = switches;
        strobe(2);
        check("nbfm_busy", int'(bus.busy), 1);
        check("nbfm_type_hold", int'(bus.demod_type), 0);
        drive_phase("nbfm_dn", 128, 256, -1, -32768, 32767);
        send(-32768, 32767);
        check("half_gain_l", got_l, -16384);
        check("half_gain_r", got_r, 16383);
        drive_phase("nbfm_dn_tail", 127, 127, -1, -32768, 32767);
        tick();
        check("nbfm_type", int'(bus.demod_type), 2);
        check("nbfm_flush_clks", flush_clks - fc0, 4);
        check("nbfm_switches", switches - sw0, 1);
        check("nbfm_flush_off", int'(bus.flush), 0);
        drive_phase("nbfm_settle", 16, 0, 0, 1000, -1000);
        check("nbfm_busy_settle", int'(bus.busy), 1);
        drive_phase("nbfm_up", 256, 1, 1, 1000, -1000);
        check("nbfm_busy_done", int'(bus.busy), 0);

        // Same-type request with type 2
        fc0 = flush_clks;
        strobe(2);
        tick();
        check("same2_busy", int'(bus.busy), 0);
        send(1000, -1000);
        check("same2_l", got_l, 1000);
        check("same2_flush", flush_clks - fc0, 0);
        check("same2_type", int'(bus.demod_type), 2);

        // Newest request wins during RAMP_DN
        fc0 = flush_clks;
        sw0 = switches;
        strobe(6);
        drive_phase("nw_dn_a", 156, 256, -1, 1000, -1000);
        check("nw_type_mid", int'(bus.demod_type), 2);
        strobe(6);
        strobe(0);
        drive_phase("nw_dn_b", 100, 100, -1, 1000, -1000);
        tick();
        check("nw_type", int'(bus.demod_type), 0);
        check("nw_switches", switches - sw0, 1);
        check("nw_flush_clks", flush_clks - fc0, 4);
        drive_phase("nw_settle", 16, 0, 0, 1000, -1000);
        drive_phase("nw_up", 256, 1, 1, 1000, -1000);
        check("nw_busy_done", int'(bus.busy), 0);

        // Request and sample in the same clock, then abort from SETTLE
        fc0 = flush_clks;
        sw0 = switches;
        bus.req_type = 3'd2;
        bus.req_stb  = 1'b1;
        bus.l_in     = 16'sd1000;
        bus.r_in     = -16'sd1000;
        bus.in_valid = 1'b1;
        tick();
        bus.req_stb  = 1'b0;
        bus.in_valid = 1'b0;
        check("simul_l", int'(bus.l_out), 1000);
        check("simul_busy", int'(bus.busy), 1);
        tick();
        tick();
        tick();
        drive_phase("simul_dn", 255, 255, -1, 1000, -1000);
        tick();
        check("simul_type", int'(bus.demod_type), 2);
        check("simul_switches", switches - sw0, 1);
        drive_phase("abort_settle", 5, 0, 0, 1000, -1000);
        strobe(6);
        check("abort_busy", int'(bus.busy), 1);
        check("abort_type_hold", int'(bus.demod_type), 2);
        send(1000, -1000);
        check("abort_l", got_l, 0);
        tick();
        check("abort_type", int'(bus.demod_type), 6);
        check("abort_switches", switches - sw0, 2);
        check("abort_flush_clks", flush_clks - fc0, 8);
        drive_phase("raw_settle", 16, 0, 0, 1000, -1000);
        drive_phase("raw_up", 50, 1, 1, 1000, -1000);
        check("raw_up_l50", got_l, 195);

        // Asynchronous reset in the middle of RAMP_UP
        #2;
        reset = 1'b0;
        #1;
        check("areset_l",     int'(bus.l_out), 0);
        check("areset_r",     int'(bus.r_out), 0);
        check("areset_type",  int'(bus.demod_type), 0);
        check("areset_busy",  int'(bus.busy), 1);
        check("areset_valid", int'(bus.valid), 0);
        check("areset_flush", int'(bus.flush), 0);
        tick();
        reset = 1'b1;
        tick();
        drive_phase("restart_settle", 16, 0, 0, 1000, -1000);
        send(1000, -1000);
        check("restart_l1", got_l, 3);
        send(1000, -1000);
        check("restart_l2", got_l, 7);
        check("restart_busy", int'(bus.busy), 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
